// File: rtl/uart_tx_queue_if.sv
// uart_tx_queue_if: host write port plus transmitter handshake.
// gap_cycles exists only when UART_TXQ_GAP_EN is defined.
interface uart_tx_queue_if #(
  parameter int DEPTH = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              wr_en;
  logic [7:0]        wr_data;
  logic              flush;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              busy;
  logic              data_ready;
  logic [7:0]        data;
  logic              tx_complete;
`ifdef UART_TXQ_GAP_EN
  logic [15:0]       gap_cycles;
`endif

  modport master (
`ifdef UART_TXQ_GAP_EN
    output gap_cycles,
`endif
    output wr_en, wr_data, flush,
    output tx_complete,
    input  full, empty, level,
    input  overflow, busy,
    input  data_ready, data
  );

  modport slave (
`ifdef UART_TXQ_GAP_EN
    input  gap_cycles,
`endif
    input  wr_en, wr_data, flush,
    input  tx_complete,
    output full, empty, level,
    output overflow, busy,
    output data_ready, data
  );
endinterface

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding the UART transmitter one strobe
// per tx_complete. Define UART_TXQ_GAP_EN for an inter-byte gap.
module uart_tx_queue #(
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_queue_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CW     = ADDR_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
`ifdef UART_TXQ_GAP_EN
  localparam logic [1:0] S_GAP  = 2'd2;
`endif

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [1:0]        r_state;
  logic              r_overflow;
  logic              r_data_ready;
  logic [7:0]        r_data;
`ifdef UART_TXQ_GAP_EN
  logic [15:0]       r_gap;
`endif

  logic w_full;
  logic w_empty;
  logic w_wr;
  logic w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_wr    = bus.wr_en & ~w_full
                 & ~bus.flush;
  assign w_pop   = (r_state == S_IDLE)
                 & ~w_empty & ~bus.flush;

  // byte storage, written only on an accepted write
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= bus.wr_data;
  end

  // pointers and occupancy count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // sticky overflow on any write seen while full
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_overflow <= 1'b0;
    else if (bus.flush)
      r_overflow <= 1'b0;
    else if (bus.wr_en && w_full)
      r_overflow <= 1'b1;
  end

  // registered strobe and byte towards the transmitter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_ready <= 1'b0;
      r_data       <= '0;
    end else begin
      r_data_ready <= w_pop;
      if (w_pop) r_data <= r_mem[r_rd_ptr];
    end
  end

  // handshake sequencer: one byte out per tx_complete
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
`ifdef UART_TXQ_GAP_EN
      r_gap   <= '0;
`endif
    end else begin
      unique case (1'b1)
        (r_state == S_IDLE): begin
          if (w_pop) r_state <= S_WAIT;
        end
        (r_state == S_WAIT): begin
          if (bus.tx_complete) begin
`ifdef UART_TXQ_GAP_EN
            r_state <= S_GAP;
            r_gap   <= bus.gap_cycles;
`else
            r_state <= S_IDLE;
`endif
          end
        end
`ifdef UART_TXQ_GAP_EN
        (r_state == S_GAP): begin
          if (r_gap == '0)
            r_state <= S_IDLE;
          else
            r_gap <= r_gap - 16'd1;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.full       = w_full;
  assign bus.empty      = w_empty;
  assign bus.level      = r_count;
  assign bus.overflow   = r_overflow;
  assign bus.busy       = (r_state != S_IDLE)
                        | ~w_empty;
  assign bus.data_ready = r_data_ready;
  assign bus.data       = r_data;
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed bench for uart_tx_queue, DEPTH=16.
// Strobed bytes are captured on the falling edge into rx_q.
module tb_uart_tx_queue;
`ifdef UART_TXQ_GAP_EN
  localparam int LAT  = 7;
  localparam int GAPW = 6;
`else
  localparam int LAT  = 1;
  localparam int GAPW = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   errors   = 0;
  int   n_strobe = 0;
  logic [7:0] rx_q [$];

  uart_tx_queue_if #(.DEPTH(16)) bus ();

  uart_tx_queue #(.DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.data_ready === 1'b1) begin
      rx_q.push_back(bus.data);
      n_strobe++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_burst(input logic [7:0] base,
                             input int n);
    for (int i = 0; i < n; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = base + 8'(i);
      tick(1);
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse_tx();
    bus.tx_complete = 1'b1;
    tick(1);
    bus.tx_complete = 1'b0;
  endtask

  task automatic serve_one(input logic [7:0] exp,
                           input int gap);
    int t;
    int s0;
    t = 0;
    while (rx_q.size() == 0 && t < 50) begin
      tick(1);
      t++;
    end
    chk("strobe_seen", 32'(rx_q.size() != 0), 1);
    if (rx_q.size() != 0)
      chk("byte_order", 32'(rx_q.pop_front()), 32'(exp));
    s0 = n_strobe;
    tick(gap);
    chk("one_strobe", n_strobe - s0, 0);
    pulse_tx();
  endtask

  initial begin
    int lat;
    int s0;
    rst             = 1'b0;
    bus.wr_en       = 1'b0;
    bus.wr_data     = '0;
    bus.flush       = 1'b0;
    bus.tx_complete = 1'b0;
`ifdef UART_TXQ_GAP_EN
    bus.gap_cycles  = 16'd5;
`endif
    tick(2);
    chk("rst_level", bus.level, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_dr", bus.data_ready, 0);
    chk("rst_data", bus.data, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b1;
    tick(1);

    // single byte latency
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hA5;
    tick(1);
    bus.wr_en = 1'b0;
    chk("n_level", bus.level, 1);
    chk("n_dr", bus.data_ready, 0);
    tick(1);
    chk("n1_dr", bus.data_ready, 1);
    chk("n1_data", bus.data, 8'hA5);
    chk("n1_level", bus.level, 0);
    chk("n1_busy", bus.busy, 1);
    tick(1);
    chk("n2_dr", bus.data_ready, 0);
    chk("n2_hold", bus.data, 8'hA5);
    chk("n2_rxq", rx_q.size(), 1);
    chk("n2_rxb", rx_q[0], 8'hA5);
    rx_q.delete();
    tick(18);
    chk("wait_nostrobe", n_strobe, 1);
    pulse_tx();
    tick(GAPW);
    chk("done_busy", bus.busy, 0);

    // tx_complete while idle is ignored
    pulse_tx();
    tick(2);
    chk("idle_tx_strobe", n_strobe, 1);
    chk("idle_tx_busy", bus.busy, 0);

    // order and wrap: 40 bytes in bursts of 8
    for (int b = 0; b < 5; b++) begin
      write_burst(8'(b * 8), 8);
      for (int k = 0; k < 8; k++)
        serve_one(8'(b * 8 + k), 10);
    end
    tick(3 + GAPW);
    chk("wrap_empty", bus.empty, 1);
    chk("wrap_busy", bus.busy, 0);
    chk("wrap_rxq", rx_q.size(), 0);
    chk("wrap_count", n_strobe, 41);

    // full, overflow, flush with a byte in flight
    write_burst(8'h60, 1);
    tick(1);
    write_burst(8'h70, 16);
    chk("f16_full", bus.full, 1);
    chk("f16_level", bus.level, 16);
    chk("f16_ovf", bus.overflow, 0);
    write_burst(8'h80, 1);
    chk("f17_level", bus.level, 16);
    chk("f17_ovf", bus.overflow, 1);
    chk("f17_full", bus.full, 1);
    bus.flush   = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h99;
    tick(1);
    bus.flush = 1'b0;
    bus.wr_en = 1'b0;
    chk("fl_level", bus.level, 0);
    chk("fl_ovf", bus.overflow, 0);
    chk("fl_empty", bus.empty, 1);
    chk("fl_busy", bus.busy, 1);
    tick(3);
    chk("fl_dr", bus.data_ready, 0);
    pulse_tx();
    tick(3 + GAPW);
    chk("fl_done_busy", bus.busy, 0);
    chk("fl_rxq", rx_q.size(), 1);
    chk("fl_rxb", rx_q[0], 8'h60);
    rx_q.delete();

    // write on the pop cycle while full
    write_burst(8'h90, 1);
    tick(1);
    write_burst(8'hA0, 16);
    chk("wp_level16", bus.level, 16);
    pulse_tx();
    chk("wp_idle_dr", bus.data_ready, 0);
    tick(GAPW);
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h55;
    tick(1);
    bus.wr_en = 1'b0;
    chk("wp_level", bus.level, 15);
    chk("wp_ovf", bus.overflow, 1);
    chk("wp_dr", bus.data_ready, 1);
    chk("wp_data", bus.data, 8'hA0);
    tick(1);
    chk("wp_rxq", rx_q.size(), 2);
    chk("wp_rx0", rx_q[0], 8'h90);
    chk("wp_rx1", rx_q[1], 8'hA0);
    rx_q.delete();
    pulse_tx();
    for (int k = 1; k < 16; k++)
      serve_one(8'hA0 + 8'(k), 2);
    tick(3 + GAPW);
    chk("wp_empty", bus.empty, 1);
    chk("wp_rxq_end", rx_q.size(), 0);
    chk("wp_ovf_sticky", bus.overflow, 1);
    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
    chk("wp_ovf_clr", bus.overflow, 0);

    // next strobe timing after tx_complete
    write_burst(8'hD0, 2);
    tick(3);
    bus.tx_complete = 1'b1;
    tick(1);
    bus.tx_complete = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (bus.data_ready === 1'b1 && lat == 0)
        lat = i;
    end
    chk("next_lat", lat, LAT);
    chk("next_rxq", rx_q.size(), 2);
    chk("next_rx1", rx_q[1], 8'hD1);
    rx_q.delete();
    pulse_tx();
    tick(2 + GAPW);
    chk("next_busy", bus.busy, 0);

    // asynchronous reset mid-WAIT
    write_burst(8'hC0, 4);
    tick(1);
    chk("ar_level", bus.level, 3);
    chk("ar_busy", bus.busy, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_level0", bus.level, 0);
    chk("ar_empty", bus.empty, 1);
    chk("ar_full", bus.full, 0);
    chk("ar_ovf", bus.overflow, 0);
    chk("ar_dr", bus.data_ready, 0);
    chk("ar_data", bus.data, 0);
    chk("ar_busy0", bus.busy, 0);
    tick(2);
    rst = 1'b1;
    s0 = n_strobe;
    tick(5);
    chk("ar_nostrobe", n_strobe - s0, 0);
    chk("ar_post_empty", bus.empty, 1);
    chk("ar_post_busy", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
Byte queue and handshake sequencer that sits directly upstream of the UART transmitter. It accepts bytes from the host/bus side at full clock rate and buffers them in a FIFO. It hands them to the transmitter one at a time using a one-cycle data_ready strobe, and waits for the transmitter's tx_complete pulse before issuing the next byte.

Parameters:
DEPTH, 16, FIFO capacity in bytes; must be a power of two, 2..256.
ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
wr_en  input  1  host write strobe, one byte per cycle
wr_data  input  8  host byte
flush  input  1  synchronous queue clear
full  output  1  count == DEPTH
empty  output  1  count == 0
level  output  ADDR_W+1  current count, 0..DEPTH
overflow  output  1  sticky: write attempted while full
busy  output  1  state != IDLE or !empty
data_ready  output  1  one-cycle strobe to transmitter, registered
data  output  8  byte to transmitter, registered, valid while data_ready=1
tx_complete  input  1  one-cycle pulse from transmitter at end of stop bits

Behaviour:
- Reset (rst=0, async): all pointers = 0, level = 0, empty = 1, full = 0, overflow = 0, data_ready = 0, data = 0, state = IDLE, busy = 0.
- Write: when wr_en=1 and full=0, the byte is stored at wr_ptr; wr_ptr increments mod DEPTH. When wr_en=1 and full=1, the byte is dropped and overflow is set to 1.
- full is evaluated from the registered count. A write in the same cycle as a pop while full is dropped, and overflow is set.
- overflow stays set until reset or flush.
- FSM states: IDLE, WAIT (plus GAP under the optional feature).
- IDLE: if !empty, pop mem[rd_ptr] into data, set data_ready=1 for exactly one cycle, increment rd_ptr mod DEPTH, go to WAIT. Otherwise data_ready=0.
- WAIT: data_ready=0; hold data. When tx_complete=1, go to IDLE (or GAP). tx_complete while in IDLE is ignored.
- Latency: byte written at edge N into an empty queue with the FSM in IDLE gives data_ready=1 from edge N+1 to N+2.
- Next strobe: earliest at the edge after the tx_complete pulse. This matches the transmitter's IDLE sampling of data_ready.
- Simultaneous write and pop: count unchanged; both pointers advance.
- Pop never occurs when empty. Bytes are delivered strictly in write order.
- Pointer wrap: pointers are ADDR_W bits and wrap naturally. The count is a separate ADDR_W+1-bit register.
- flush=1: rd_ptr = wr_ptr = 0, count = 0, overflow = 0; a wr_en in the same cycle is discarded.
- A byte already strobed (FSM in WAIT) is not aborted. The FSM still waits for tx_complete.
- flush in IDLE suppresses any pop in that cycle.

Optional Feature:
Macro: UART_TXQ_GAP_EN.
- When defined, adds input gap_cycles [15:0] and state GAP.
- On tx_complete in WAIT, the FSM goes to GAP and loads a down-counter with gap_cycles. It returns to IDLE when the counter reaches 0; gap_cycles=0 means one GAP cycle.
- busy stays 1 during GAP; flush does not shorten GAP.
- When not defined: no gap_cycles port, no GAP state, and WAIT goes straight to IDLE on tx_complete.

Test Plan:
- Reset check: assert rst=0 mid-WAIT with level=3 -> all outputs at reset values immediately (asynchronously), busy=0; after release the queue is empty and no data_ready is issued.
- Single byte: write 0xA5 at edge N into an idle queue -> data_ready=1, data=0xA5 during N+1..N+2. Pulse tx_complete 20 cycles later -> busy=0 next cycle.
- Order and wrap: write 40 bytes 0x00..0x27 in bursts, respond to each strobe with tx_complete after 10 cycles -> bytes arrive in order, pointers wrap twice, never more than one strobe per tx_complete.
- Full/overflow: write 17 bytes back-to-back with DEPTH=16 and no tx_complete -> full=1 after 16; the 17th is dropped; overflow=1, level=16. Flush -> level=0, overflow=0, pending WAIT still completes on tx_complete.
- Simultaneous write+pop at full: at level=16, in IDLE, write 0x55 on the pop cycle -> write dropped, overflow=1, level=15.
- With UART_TXQ_GAP_EN, gap_cycles=5: two queued bytes -> second data_ready exactly 7 cycles after the first tx_complete pulse (5+1 GAP cycles, then the IDLE pop).
